// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Central stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB
//   pipeline registers. It merges I/D-cache stalls, load-use hazards and
//   EX-stage redirects into per-stage stall/flush strobes. A redirect that
//   arrives while a cache stall is in progress is held and replayed in the
//   first cycle after the stall releases. Two saturating counters track
//   stall cycles and issued redirects.
//
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   icache_stall_i        I-cache miss in progress
//   dcache_stall_i        D-cache miss in progress
//   load_use_i            load-use hazard between ID/EX and ID
//   redirect_i            EX-stage mispredict, valid this cycle
//   redirect_pc_i         target PC for redirect_i
//   pc_stall_o/pc_load_o  hold PC / load PC with pc_target_o
//   pc_target_o           redirect target
//   ifid_*, idex_*        stall/flush for IF/ID and ID/EX
//   exmem_stall_o         hold EX/MEM
//   memwb_stall_o         hold MEM/WB
//   stall_cnt_o           cycles with a cache stall, saturating
//   redir_cnt_o           redirects issued to the PC, saturating
module hazard_stall_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_stall_i,
  input  logic              dcache_stall_i,
  input  logic              load_use_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              pc_stall_o,
  output logic              pc_load_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              ifid_stall_o,
  output logic              ifid_flush_o,
  output logic              idex_stall_o,
  output logic              idex_flush_o,
  output logic              exmem_stall_o,
  output logic              memwb_stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  redir_cnt_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MSTALL = 2'd1,  // stalled, nothing pending
    MPEND  = 2'd2   // stalled, redirect pending in pend_pc_q
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]    stall_cnt_q, redir_cnt_q;
  logic                mem_stall;

  assign mem_stall = icache_stall_i | dcache_stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next state. Leaving MPEND on release is the replay cycle; the output
  // logic below issues the held redirect in that same cycle.
  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          if (redirect_i) begin
            state_d   = MPEND;
            pend_pc_d = redirect_pc_i;
          end else begin
            state_d = MSTALL;
          end
        end
      end
      MSTALL: begin
        if (!mem_stall) begin
          state_d = RUN;  // a redirect in this cycle is issued directly
        end else if (redirect_i) begin
          state_d   = MPEND;
          pend_pc_d = redirect_pc_i;
        end
      end
      MPEND: begin
        if (!mem_stall) begin
          state_d = RUN;
        end else if (redirect_i) begin
          pend_pc_d = redirect_pc_i;  // latest redirect wins
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Mealy outputs. Stall beats redirect beats load-use; a stalled stage is
  // never flushed. Everything is forced low while reset is asserted.
  always_comb begin
    pc_stall_o    = 1'b0;
    pc_load_o     = 1'b0;
    pc_target_o   = pend_pc_q;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_stall_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_stall_o = 1'b0;
    memwb_stall_o = 1'b0;
    if (!rst_n) begin
      pc_target_o = '0;
    end else if (mem_stall) begin
      pc_stall_o    = 1'b1;
      ifid_stall_o  = 1'b1;
      idex_stall_o  = 1'b1;
      exmem_stall_o = 1'b1;
      memwb_stall_o = 1'b1;
    end else if (redirect_i || state_q == MPEND) begin
      // load_use_i is ignored here: the ID instruction is wrong-path
      pc_load_o    = 1'b1;
      pc_target_o  = redirect_i ? redirect_pc_i : pend_pc_q;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use_i) begin
      pc_stall_o   = 1'b1;
      ifid_stall_o = 1'b1;
      idex_flush_o = 1'b1;  // bubble into EX
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (mem_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (pc_load_o && redir_cnt_q != '1) redir_cnt_q <= redir_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign redir_cnt_o = redir_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl. The driver applies one directed
// vector per cycle just after posedge and queues its hand-computed response;
// the monitor pops and compares on each negedge.
module tb_hazard_stall_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  // ctrl = {pc_stall, pc_load, ifid_stall, ifid_flush,
  //         idex_stall, idex_flush, exmem_stall, memwb_stall}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] STL  = 8'b1010_1011;
  localparam logic [7:0] RDR  = 8'b0101_0100;
  localparam logic [7:0] LU   = 8'b1010_0100;

  typedef struct {
    logic [7:0]        ctrl;
    logic [ADDR_W-1:0] tgt;
    logic [CNT_W-1:0]  sc;
    logic [CNT_W-1:0]  rc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              icache_stall_i, dcache_stall_i, load_use_i, redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              pc_stall_o, pc_load_o, ifid_stall_o, ifid_flush_o;
  logic              idex_stall_o, idex_flush_o, exmem_stall_o, memwb_stall_o;
  logic [ADDR_W-1:0] pc_target_o;
  logic [CNT_W-1:0]  stall_cnt_o, redir_cnt_o;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;

  hazard_stall_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_stall_i(icache_stall_i), .dcache_stall_i(dcache_stall_i),
    .load_use_i(load_use_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .pc_stall_o(pc_stall_o), .pc_load_o(pc_load_o), .pc_target_o(pc_target_o),
    .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
    .idex_stall_o(idex_stall_o), .idex_flush_o(idex_flush_o),
    .exmem_stall_o(exmem_stall_o), .memwb_stall_o(memwb_stall_o),
    .stall_cnt_o(stall_cnt_o), .redir_cnt_o(redir_cnt_o)
  );

  always #5 clk = ~clk;

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {pc_stall_o, pc_load_o, ifid_stall_o, ifid_flush_o,
             idex_stall_o, idex_flush_o, exmem_stall_o, memwb_stall_o};
      vec++;
      total++;
      if (act !== e.ctrl) begin
        bad++;
        $display("FAIL ctrl vec%0d: got %b want %b", vec, act, e.ctrl);
      end
      if (e.ctrl[6] || e.ctrl == NONE && e.tgt == '0) begin
        total++;
        if (pc_target_o !== e.tgt) begin
          bad++;
          $display("FAIL target vec%0d: got %h want %h", vec, pc_target_o, e.tgt);
        end
      end
      total++;
      if (stall_cnt_o !== e.sc || redir_cnt_o !== e.rc) begin
        bad++;
        $display("FAIL counters vec%0d: got sc=%0d rc=%0d want sc=%0d rc=%0d",
                 vec, stall_cnt_o, redir_cnt_o, e.sc, e.rc);
      end
    end
  end

  // One cycle of stimulus. rst is rst_n for the cycle; mid_rst pulls rst_n
  // low shortly after the inputs settle to exercise the async reset path.
  task automatic step(input logic rst, input logic is, input logic ds,
                      input logic lu, input logic rd, input logic [ADDR_W-1:0] pc,
                      input logic mid_rst, input logic [7:0] ctrl,
                      input logic [ADDR_W-1:0] tgt, input int sc, input int rc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = rst;
    icache_stall_i = is;
    dcache_stall_i = ds;
    load_use_i     = lu;
    redirect_i     = rd;
    redirect_pc_i  = pc;
    if (mid_rst) begin
      #1 rst_n = 1'b0;
    end
    e.ctrl = ctrl;
    e.tgt  = tgt;
    e.sc   = sc[CNT_W-1:0];
    e.rc   = rc[CNT_W-1:0];
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    icache_stall_i = 1'b0; dcache_stall_i = 1'b0;
    load_use_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

    // reset state: redirect held high while in reset must not leak out
    //   rst is ds lu rd pc        mid ctrl tgt       sc rc
    step(0, 0, 1, 1, 1, 32'h77,   0, NONE, 32'h0,  0, 0);
    step(1, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h0,  0, 0);

    // load-use bubble for one cycle only
    step(1, 0, 0, 1, 0, 32'h0,    0, LU,   32'h0,  0, 0);
    step(1, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h0,  0, 0);

    // plain redirect
    step(1, 0, 0, 0, 1, 32'h100,  0, RDR,  32'h100, 0, 0);
    step(1, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h100, 0, 1);

    // dcache stall 5 cycles, redirect 0x200 in cycle 2, replayed on release
    step(1, 0, 1, 0, 0, 32'h0,    0, STL,  32'h0,   0, 1);
    step(1, 0, 1, 0, 1, 32'h200,  0, STL,  32'h0,   1, 1);
    step(1, 0, 1, 1, 0, 32'h0,    0, STL,  32'h0,   2, 1);
    step(1, 0, 1, 0, 0, 32'h0,    0, STL,  32'h0,   3, 1);
    step(1, 0, 1, 0, 0, 32'h0,    0, STL,  32'h0,   4, 1);
    step(1, 0, 0, 0, 0, 32'h0,    0, RDR,  32'h200, 5, 1);
    step(1, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h200, 5, 2);

    // pending 0x200, release cycle brings redirect 0x300 plus load-use
    step(1, 1, 0, 0, 1, 32'h200,  0, STL,  32'h0,   5, 2);
    step(1, 1, 0, 0, 0, 32'h0,    0, STL,  32'h0,   6, 2);
    step(1, 0, 0, 1, 1, 32'h300,  0, RDR,  32'h300, 7, 2);
    step(1, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h200, 7, 3);

    // latest pending redirect wins; then load-use works again in RUN
    step(1, 0, 1, 0, 0, 32'h0,    0, STL,  32'h0,   7, 3);
    step(1, 0, 1, 0, 1, 32'h240,  0, STL,  32'h0,   8, 3);
    step(1, 1, 1, 0, 1, 32'h280,  0, STL,  32'h0,   9, 3);
    step(1, 0, 0, 0, 0, 32'h0,    0, RDR,  32'h280, 10, 3);
    step(1, 0, 0, 1, 0, 32'h0,    0, LU,   32'h0,   10, 4);

    // MSTALL released with a same-cycle redirect: issued directly
    step(1, 0, 1, 1, 0, 32'h0,    0, STL,  32'h0,   10, 4);
    step(1, 0, 0, 0, 1, 32'h2c0,  0, RDR,  32'h2c0, 11, 4);
    step(1, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h280, 11, 5);

    // async reset mid-cycle while a stall+redirect is presented
    step(1, 1, 0, 0, 1, 32'h99,   1, NONE, 32'h0,   0, 0);
    step(0, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h0,   0, 0);
    step(1, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h0,   0, 0);

    // 20 stall cycles with a redirect pending: stall_cnt saturates at 15
    step(1, 0, 1, 0, 1, 32'h400,  0, STL,  32'h0,   0, 0);
    for (int i = 1; i < 20; i++)
      step(1, 0, 1, 0, 0, 32'h0,  0, STL,  32'h0,   (i > 15) ? 15 : i, 0);
    // reset pulse while MPEND: pending redirect discarded, no replay
    step(1, 0, 1, 0, 0, 32'h0,    1, NONE, 32'h0,   0, 0);
    step(1, 0, 1, 0, 0, 32'h0,    0, STL,  32'h0,   0, 0);
    step(1, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h0,   1, 0);
    step(1, 0, 0, 0, 0, 32'h0,    0, NONE, 32'h0,   1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
